// File: rtl/common_pkg.sv
// Shared core types: address and instruction widths, reset PC, instruction-bus structs.
package common;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] u32;

  localparam addr_t PCINIT = 64'h8000_0000;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic data_ok;
    u32   data;
  } ibus_resp_t;

endpackage

// File: rtl/pipes_pkg.sv
// Inter-stage pipeline register payloads.
package pipes;

  import common::*;

  typedef struct packed {
    logic  valid;
    addr_t pc;
    u32    raw_instr;
  } fetch_data_t;

endpackage

// File: rtl/fetch_pcreg.sv
// Fetch PC register; a redirect always wins over sequential advance.
module pcreg
  import common::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_redirect,
  input  addr_t i_redirect_pc,
  input  logic  i_advance,
  output addr_t o_pc
);

  addr_t r_pc;
  addr_t w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = i_redirect_pc;
    end else if (i_advance) begin
      w_pc_next = r_pc + 64'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= PCINIT;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch.sv
// Instruction fetch: one outstanding bus request, registered output to decode,
// and a discard flag that drops the single in-flight response after a redirect.
module fetch
  import common::*;
  import pipes::*;
(
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  addr_t       redirect_pc,
  input  logic        stall,
  output fetch_data_t dataF
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      r_state, w_state_next;
  fetch_data_t r_outf, w_outf_next;
  logic        r_discard, w_discard_next;
  addr_t       r_req_addr, w_req_addr_next;
  addr_t       w_pc;
  logic        w_space;
  logic        w_issue;
  logic        w_advance;

  pcreg u_pcreg (
    .clk           (clk),
    .reset         (reset),
    .i_redirect    (redirect_valid),
    .i_redirect_pc (redirect_pc),
    .i_advance     (w_advance),
    .o_pc          (w_pc)
  );

  assign w_space = !r_outf.valid || !stall;

  always_comb begin
    w_state_next    = r_state;
    w_outf_next     = r_outf;
    w_discard_next  = r_discard;
    w_req_addr_next = r_req_addr;
    w_advance       = 1'b0;
    w_issue         = 1'b0;
    ireq            = '0;
    if (r_outf.valid && !stall) begin
      w_outf_next.valid = 1'b0;
    end
    case (r_state)
      IDLE: begin
        w_issue   = w_space && !redirect_valid && !reset;
        ireq.addr = w_pc;
        if (w_issue) begin
          w_req_addr_next = w_pc;
          if (iresp.data_ok) begin
            w_outf_next.valid     = 1'b1;
            w_outf_next.pc        = w_pc;
            w_outf_next.raw_instr = iresp.data;
            w_advance             = 1'b1;
          end else begin
            w_state_next = REQ;
          end
        end
      end
      REQ: begin
        // Bus address is latched: pc may already point at a redirect target.
        w_issue   = !reset;
        ireq.addr = r_req_addr;
        if (iresp.data_ok) begin
          w_state_next   = IDLE;
          w_discard_next = 1'b0;
          if (!r_discard && !redirect_valid) begin
            w_outf_next.valid     = 1'b1;
            w_outf_next.pc        = r_req_addr;
            w_outf_next.raw_instr = iresp.data;
            w_advance             = 1'b1;
          end
        end else if (redirect_valid) begin
          w_discard_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (redirect_valid) begin
      w_outf_next.valid = 1'b0;
    end
    ireq.valid = w_issue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_outf     <= '0;
      r_discard  <= 1'b0;
      r_req_addr <= PCINIT;
    end else begin
      r_state    <= w_state_next;
      r_outf     <= w_outf_next;
      r_discard  <= w_discard_next;
      r_req_addr <= w_req_addr_next;
    end
  end

  assign dataF = r_outf;

endmodule

// File: tb/tb_fetch.sv
// Randomized self-checking bench for fetch: memory responder, expected-stream scoreboard,
// and bus/hold protocol monitors.
module tb_fetch;

  import common::*;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset;
  ibus_req_t   ireq;
  ibus_resp_t  iresp = '0;
  logic        redirect_valid;
  addr_t       redirect_pc;
  logic        stall;
  fetch_data_t dataF;

  always #5 clk = ~clk;

  fetch dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .dataF          (dataF)
  );

  typedef struct packed {
    addr_t pc;
    u32    instr;
  } exp_t;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_pop = 0;
  exp_t  exp_q[$];
  addr_t next_push;
  int    lat_mode = 0;
  bit    pend = 0;
  int    cnt = 0;
  addr_t paddr;
  bit    new_req_seen = 0;
  addr_t new_req_addr;

  function automatic u32 mem(addr_t a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  function automatic void topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back('{pc: next_push, instr: mem(next_push)});
      next_push = next_push + 64'd4;
    end
  endfunction

  function automatic void set_stream(addr_t a);
    exp_q.delete();
    next_push = a;
    topup();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    topup();
  endtask

  // Memory: latency 0 answers in the issue cycle, latency N on the N-th following cycle.
  always @(negedge clk) begin
    iresp.data_ok = 1'b0;
    iresp.data    = $urandom;
    if (reset) begin
      pend = 0;
    end else if (ireq.valid) begin
      if (!pend) begin
        pend         = 1;
        paddr        = ireq.addr;
        cnt          = (lat_mode >= 0) ? lat_mode : int'($urandom_range(0, 3));
        new_req_seen = 1;
        new_req_addr = ireq.addr;
      end
      if (cnt == 0) begin
        iresp.data_ok = 1'b1;
        iresp.data    = mem(paddr);
        pend          = 0;
      end else begin
        cnt--;
      end
    end
  end

  // Monitor: protocol invariants plus in-order comparison of every consumed dataF.
  logic        p_wait = 1'b0;
  addr_t       p_addr;
  logic        p_hold = 1'b0;
  fetch_data_t p_data;

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (reset) begin
      check("ireq_valid_in_reset", 128'(ireq.valid), 128'(0));
      p_wait = 1'b0;
      p_hold = 1'b0;
    end else begin
      if (p_wait) check("req_held", {ireq.valid, ireq.addr}, {1'b1, p_addr});
      if (p_hold) check("dataF_held", dataF, p_data);
      if (dataF.valid && stall) check("no_req_while_full", 128'(ireq.valid), 128'(0));
      if (!redirect_valid && dataF.valid && !stall) begin
        if (exp_q.size() == 0) begin
          check("stream_underflow", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("dataF", {dataF.pc, dataF.raw_instr}, {e.pc, e.instr});
        end
      end
      p_wait = ireq.valid && !iresp.data_ok;
      p_addr = ireq.addr;
      p_hold = dataF.valid && stall && !redirect_valid;
      p_data = dataF;
    end
  end

  task automatic wait_pend(int want_cnt);
    int i;
    for (i = 0; i < 60 && !(pend && cnt == want_cnt); i++) tick();
    check("pend_wait", 128'(pend && cnt == want_cnt), 128'(1));
  endtask

  task automatic do_redirect(addr_t target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    set_stream(target);
    new_req_seen   = 0;
  endtask

  task automatic expect_next_req(string name, addr_t target);
    int i;
    for (i = 0; i < 60 && !new_req_seen; i++) tick();
    check(name, {new_req_seen, new_req_addr}, {1'b1, target});
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    lat_mode       = 0;
    set_stream(PCINIT);
    repeat (3) tick();
    reset = 1'b0;

    // Zero-wait boot: one fetch per cycle from PCINIT.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #2;
      check("boot_addr", {ireq.valid, ireq.addr}, {1'b1, PCINIT + 64'(4 * k)});
      if (k == 0) check("boot_dataF_invalid", 128'(dataF.valid), 128'(0));
      if (k == 1) check("boot_dataF", dataF, {1'b1, PCINIT, mem(PCINIT)});
    end
    tick();

    lat_mode = 3;
    repeat (20) tick();

    // Stall held with a valid output.
    lat_mode = 0;
    for (int i = 0; i < 20 && !dataF.valid; i++) tick();
    check("stall_setup", 128'(dataF.valid), 128'(1));
    stall = 1'b1;
    repeat (4) tick();
    stall = 1'b0;
    repeat (4) tick();

    // Redirect while a request is outstanding.
    lat_mode = 3;
    wait_pend(2);
    do_redirect(PCINIT + 64'h100);
    tick();
    redirect_valid = 1'b0;
    expect_next_req("redirect_target", PCINIT + 64'h100);
    repeat (10) tick();

    // Redirect in the same cycle as data_ok.
    wait_pend(0);
    do_redirect(PCINIT + 64'h180);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    #2;
    check("concurrent_drop", 128'(dataF.valid), 128'(0));
    expect_next_req("concurrent_target", PCINIT + 64'h180);
    repeat (10) tick();

    // Two redirects inside one pending transaction.
    wait_pend(2);
    do_redirect(PCINIT + 64'h200);
    tick();
    do_redirect(PCINIT + 64'h300);
    tick();
    redirect_valid = 1'b0;
    expect_next_req("double_redirect_target", PCINIT + 64'h300);
    repeat (10) tick();

    // Random traffic with a mid-run reset.
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        redirect_valid = 1'b0;
        stall          = 1'b0;
        reset          = 1'b1;
        set_stream(PCINIT);
        tick();
        tick();
        reset = 1'b0;
      end
      tick();
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if (redirect_valid) begin
        redirect_pc = PCINIT + {50'd0, 12'($urandom_range(0, 1023)), 2'b00};
        set_stream(redirect_pc);
      end else begin
        redirect_pc = 64'($urandom);
      end
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    repeat (10) tick();
    check("progress", 128'(n_pop > 300), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ireq  output  ibus_req_t  instruction-bus request: valid, addr (addr_t, 64).
REQ-004 iresp  input  ibus_resp_t  instruction-bus response: data_ok (1), data (u32 instruction).
REQ-005 redirect_valid  input  1  execute stage resolved a taken branch/JAL/JALR this cycle.
REQ-006 redirect_pc  input  addr_t  target from execute next-PC logic; meaningful only with redirect_valid.
REQ-007 stall  input  1  decode cannot accept dataF this cycle.
REQ-008 dataF  output  fetch_data_t  registered {valid, pc (addr_t), raw_instr (u32)} to decode.

Function
REQ-009 Internal state SHALL be pc (addr_t), output register outF, discard flag (1), and FSM state in {IDLE, REQ}.
REQ-010 space SHALL be (!outF.valid | !stall); outF is consumed on any edge where outF.valid & !stall.
REQ-011 IDLE: ireq.valid SHALL be space & !redirect_valid, with ireq.addr = pc.
REQ-012 IDLE with request issued and no data_ok SHALL go to REQ next cycle.
REQ-013 REQ: ireq.valid SHALL be 1 with ireq.addr unchanged every cycle until data_ok; the request is never withdrawn.
REQ-014 On data_ok with discard=0 and no redirect_valid: outF <= {1, pc, iresp.data}; pc <= pc + 4 (64-bit wrap); state <= IDLE.
REQ-015 A zero-wait response (data_ok in the IDLE issue cycle) SHALL be captured as in REQ-014.
REQ-016 On redirect_valid: pc <= redirect_pc, outF.valid <= 0 on the same edge, overriding REQ-014; redirect_pc is used unmodified.
REQ-017 redirect_valid in REQ without data_ok SHALL set discard; the request completes and its data is dropped.
REQ-018 data_ok with discard=1 or concurrent redirect_valid SHALL drop data, clear discard, go IDLE, leave pc at the redirect target.
REQ-019 A second redirect while discard=1 SHALL update pc only; at most one transaction is discarded.
REQ-020 outF SHALL hold value while outF.valid & stall; no new request issues until space.
REQ-021 Steady state with 1-cycle-latency memory and no stall: throughput one instruction per 2 cycles; zero-wait memory: one per cycle.

Reset
REQ-022 While reset is high: pc <= PCINIT (64'h8000_0000), state <= IDLE, discard <= 0, outF <= '0.
REQ-023 During the reset cycle ireq.valid SHALL be 0; dataF.valid is 0 in the cycle after reset deasserts.
REQ-024 Reset mid-transaction SHALL abandon the outstanding request with no discard tracking; the bus is reset with the core.

Structure
REQ-025 fetch_data_t SHALL be defined in pipes.
REQ-026 PCINIT, addr_t, u32, ibus_req_t, and ibus_resp_t SHALL come from common.
REQ-027 The FSM state enum SHALL be module-local.
REQ-028 One sub-module, pcreg, SHALL hold pc and its next-value mux (reset / redirect / +4 / hold).
REQ-029 Expected size: 120-250 lines.

Verification
REQ-030 Reset release, zero-wait memory returning 0x00000013: first ireq.addr=0x80000000; dataF {1, 0x80000000, 0x13} next cycle; subsequent addrs 0x80000004, 0x80000008 on consecutive cycles.
REQ-031 3-cycle memory latency: ireq.valid/addr stable for 3 cycles; exactly one dataF per transaction.
REQ-032 stall held 4 cycles with dataF valid at pc 0x80000004: dataF unchanged, ireq.valid=0 throughout; fetch resumes 0x80000008 after release.
REQ-033 redirect_valid with redirect_pc=0x80000100 during an outstanding request to 0x80000010: 0x80000010 data never reaches dataF; next ireq.addr=0x80000100.
REQ-034 redirect same cycle as data_ok: data dropped, dataF.valid=0 next cycle, next request to redirect_pc.
REQ-035 Two redirects (0x80000200 then 0x80000300) within one pending transaction: single discard; next fetch at 0x80000300.
